esaxi_wr: RTL

AXI3 slave-side write channel responder: accepts one write burst at a time on AW/W, turns each data beat into a local write access with a computed beat address, and returns the B response. It is the responder for the write bursts our `emaxi` master issues. It terminates the master's AW/W/B channels and drives the same local `wr_*` access style used across the mesh side of the design.

---
 rtl/esaxi_wr.sv | 100 ++++++++++
 1 files changed

// File: rtl/esaxi_wr.sv
// AXI3 slave write responder: one burst at a time on AW/W, one local wr_* access
// per accepted beat, then a single B response.
module esaxi_wr (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] s_axi_awid,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [11:0] s_axi_wid,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [11:0] s_axi_bid,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic        wr_access,
    output logic [31:0] wr_addr,
    output logic [63:0] wr_data,
    output logic [7:0]  wr_strb,
    input  logic        wr_wait
);

    typedef enum logic [1:0] {RST_HOLD, IDLE, DATA, RESP} state_t;

    state_t      state, state_nxt;
    logic [11:0] id_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic        fixed_q;
    logic [31:0] addr;
    logic [7:0]  cnt;
    logic        err;

    logic aw_hs, beat, last_beat, beat_err;

    assign s_axi_awready = (state == IDLE);
    assign s_axi_wready  = (state == DATA) && !wr_wait;
    assign s_axi_bvalid  = (state == RESP);
    assign s_axi_bid     = id_q;
    assign s_axi_bresp   = {err, 1'b0};

    assign aw_hs     = s_axi_awvalid && s_axi_awready;
    assign beat      = s_axi_wvalid && s_axi_wready;
    assign last_beat = (cnt == len_q);
    // Protocol violations on a beat only poison later beats, not this one.
    assign beat_err  = (s_axi_wid != id_q) || (s_axi_wlast != last_beat);

    assign wr_access = beat && !err;
    assign wr_addr   = addr;
    assign wr_data   = s_axi_wdata;
    assign wr_strb   = s_axi_wstrb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RST_HOLD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST_HOLD: state_nxt = IDLE;
            IDLE:     if (aw_hs) state_nxt = DATA;
            DATA:     if (beat && last_beat) state_nxt = RESP;
            RESP:     if (s_axi_bready) state_nxt = IDLE;
            default:  state_nxt = RST_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q    <= '0;
            len_q   <= '0;
            size_q  <= '0;
            fixed_q <= 1'b0;
            addr    <= '0;
            cnt     <= '0;
            err     <= 1'b0;
        end else if (aw_hs) begin
            id_q    <= s_axi_awid;
            len_q   <= s_axi_awlen;
            size_q  <= s_axi_awsize;
            fixed_q <= !s_axi_awburst[0];
            addr    <= s_axi_awaddr;
            cnt     <= '0;
            err     <= s_axi_awburst[1] || (s_axi_awsize > 3'd3);
        end else if (beat) begin
            cnt <= cnt + 8'd1;
            if (!fixed_q) addr <= addr + (32'd1 << size_q);
            if (beat_err) err <= 1'b1;
        end
    end

endmodule
